// File: rtl/timer_pkg.sv
// Shared types and constants for the down_timer block and its sub-modules.
package timer_pkg;

   localparam int TIMER_WIDTH_DEFAULT = 4;

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      DONE
   } timer_state_t;

endpackage

// File: rtl/down_timer_if.sv
// Control/status bundle of the down_timer: the requester drives the master side.
interface down_timer_if
   import timer_pkg::*;
#(
   parameter int WIDTH = TIMER_WIDTH_DEFAULT
);

   logic             start;
   logic [WIDTH-1:0] period;
   logic             auto_reload;
   logic             enable;
   logic             abort;
   logic [WIDTH-1:0] count;
   logic             busy;
   logic             tc;
   logic             done;

   modport master (
      output start, period, auto_reload, enable, abort,
      input  count, busy, tc, done
   );

   modport slave (
      input  start, period, auto_reload, enable, abort,
      output count, busy, tc, done
   );

endinterface

// File: rtl/down_counter_core.sv
// Loadable down-counter that saturates at zero; load takes priority over decrement.
module down_counter_core #(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             load,
   input  logic [WIDTH-1:0] load_value,
   input  logic             dec_en,
   output logic [WIDTH-1:0] count,
   output logic             is_zero
);

   localparam logic [WIDTH-1:0] ONE = 1;

   logic [WIDTH-1:0] r_count;

   // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_count <= '0;
      end else if (load) begin
         r_count <= load_value;
      end else if (dec_en && (r_count != '0)) begin
         r_count <= r_count - ONE;
      end
   end

   assign count   = r_count;
   assign is_zero = (r_count == '0);

endmodule

// File: rtl/down_timer.sv
// Programmable down-counting interval timer with one-shot and auto-reload modes.
module down_timer
   import timer_pkg::*;
#(
   parameter int WIDTH = TIMER_WIDTH_DEFAULT
) (
   input  logic      clk,
   input  logic      reset_n,
   down_timer_if.slave bus
);

   timer_state_t     r_state;
   logic [WIDTH-1:0] r_reload;
   logic             r_mode;
   logic             r_busy;
   logic             r_tc;
   logic             r_done;

   logic             w_load;
   logic [WIDTH-1:0] w_load_value;
   logic             w_dec_en;
   logic             w_is_zero;

   // NOTE: every combinational output gets a default first so no latch is inferred.
   always_comb begin
      w_load       = 1'b0;
      w_load_value = '0;
      w_dec_en     = 1'b0;
      if (bus.abort) begin
         w_load = 1'b1;
      end else begin
         case (r_state)
            IDLE, DONE: begin
               if (bus.start) begin
                  w_load       = 1'b1;
                  w_load_value = bus.period;
               end
            end
            RUN: begin
               if (bus.enable) begin
                  if (!w_is_zero) begin
                     w_dec_en = 1'b1;
                  end else if (r_mode) begin
                     w_load       = 1'b1;
                     w_load_value = r_reload;
                  end
               end
            end
            default: ;
         endcase
      end
   end

   down_counter_core #(.WIDTH(WIDTH)) u_core (
      .clk        (clk),
      .reset_n    (reset_n),
      .load       (w_load),
      .load_value (w_load_value),
      .dec_en     (w_dec_en),
      .count      (bus.count),
      .is_zero    (w_is_zero)
   );

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state  <= IDLE;
         r_reload <= '0;
         r_mode   <= 1'b0;
         r_busy   <= 1'b0;
         r_tc     <= 1'b0;
         r_done   <= 1'b0;
      end else begin
         r_tc <= 1'b0;
         if (bus.abort) begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
         end else begin
            case (r_state)
               IDLE, DONE: begin
                  if (bus.start) begin
                     r_reload <= bus.period;
                     r_mode   <= bus.auto_reload;
                     r_busy   <= 1'b1;
                     r_done   <= 1'b0;
                     r_state  <= RUN;
                  end
               end
               RUN: begin
                  // Terminal count is seen one enabled edge after count reaches zero.
                  if (bus.enable && w_is_zero) begin
                     r_tc <= 1'b1;
                     if (!r_mode) begin
                        r_state <= DONE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                     end
                  end
               end
               default: r_state <= IDLE;
            endcase
         end
      end
   end

   assign bus.busy = r_busy;
   assign bus.tc   = r_tc;
   assign bus.done = r_done;

endmodule

// File: tb/tb_down_timer.sv
// Self-checking bench for down_timer: directed scenarios plus random traffic against an interval model.
module tb_down_timer;

   localparam int W = 4;

   logic clk = 1'b0;
   logic reset_n;

   down_timer_if #(.WIDTH(W)) tif ();

   down_timer #(.WIDTH(W)) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (tif.slave)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
      end
   endtask

   // Model: the timer is idle, running or done; while running, the outputs follow
   // from how many enabled edges (m_e) have elapsed since the accepted start.
   typedef enum int {M_IDLE, M_RUN, M_DONE} mstate_t;
   mstate_t m_state = M_IDLE;
   int      m_n     = 0;
   int      m_e     = 0;
   bit      m_auto  = 1'b0;
   bit      m_tc    = 1'b0;

   task automatic model_reset();
      m_state = M_IDLE;
      m_n     = 0;
      m_e     = 0;
      m_auto  = 1'b0;
      m_tc    = 1'b0;
   endtask

   task automatic model_step();
      m_tc = 1'b0;
      if (!reset_n || tif.abort) begin
         m_state = M_IDLE;
         m_e     = 0;
      end else if (m_state != M_RUN && tif.start) begin
         m_state = M_RUN;
         m_n     = int'(tif.period);
         m_auto  = tif.auto_reload;
         m_e     = 0;
      end else if (m_state == M_RUN && tif.enable) begin
         m_e++;
         if (m_auto) begin
            m_tc = (m_e % (m_n + 1)) == 0;
         end else if (m_e == m_n + 1) begin
            m_tc    = 1'b1;
            m_state = M_DONE;
         end
      end
   endtask

   task automatic check_all(input string tag);
      int exp_count;
      if (m_state == M_IDLE || m_state == M_DONE) exp_count = 0;
      else if (m_auto) exp_count = m_n - (m_e % (m_n + 1));
      else exp_count = (m_e >= m_n) ? 0 : m_n - m_e;
      check({tag, ".count"}, 32'(tif.count), 32'(exp_count));
      check({tag, ".busy"},  32'(tif.busy),  32'(m_state == M_RUN));
      check({tag, ".tc"},    32'(tif.tc),    32'(m_tc));
      check({tag, ".done"},  32'(tif.done),  32'(m_state == M_DONE));
   endtask

   task automatic drive(input logic st, input int per, input logic ar, input logic en, input logic ab);
      tif.start       = st;
      tif.period      = W'(per);
      tif.auto_reload = ar;
      tif.enable      = en;
      tif.abort       = ab;
   endtask

   task automatic tick(input string tag);
      @(posedge clk);
      model_step();
      #1;
      check_all(tag);
   endtask

   task automatic ticks(input string tag, input int n);
      for (int i = 0; i < n; i++) tick(tag);
   endtask

   initial begin
      reset_n = 1'b0;
      drive(0, 0, 0, 0, 0);
      model_reset();
      #12;
      check_all("reset");
      @(posedge clk);
      #1 reset_n = 1'b1;
      ticks("idle", 2);

      // One-shot, period 3
      drive(1, 3, 0, 1, 0); tick("os3_start");
      drive(0, 3, 0, 1, 0); ticks("os3", 7);

      // Auto-reload, period 2
      drive(1, 2, 1, 1, 0); tick("ar2_start");
      drive(0, 2, 1, 1, 0); ticks("ar2", 10);
      drive(0, 2, 1, 1, 1); tick("ar2_abort");

      // One-shot, period 5, enable gap at count 3
      drive(1, 5, 0, 1, 0); tick("os5_start");
      drive(0, 5, 0, 1, 0); ticks("os5", 2);
      drive(0, 5, 0, 0, 0); ticks("os5_gap", 4);
      drive(0, 5, 0, 1, 0); ticks("os5_resume", 6);

      // Auto-reload 7, ignored restart with new period, then abort cases
      drive(1, 7, 1, 1, 0); tick("ar7_start");
      drive(0, 7, 1, 1, 0); ticks("ar7", 3);
      drive(1, 1, 0, 1, 0); tick("ar7_restart_ignored");
      drive(0, 1, 0, 1, 0); ticks("ar7_cont", 10);
      drive(0, 1, 0, 1, 1); tick("ar7_abort");
      drive(0, 1, 0, 1, 0); tick("after_abort");
      drive(1, 4, 1, 1, 1); tick("start_and_abort");
      drive(0, 4, 1, 1, 0); ticks("post_start_abort", 2);

      // Period 0 one-shot, then restart from DONE
      drive(1, 0, 0, 1, 0); tick("os0_start");
      drive(0, 0, 0, 1, 0); ticks("os0", 3);
      drive(1, 2, 0, 1, 0); tick("done_restart");
      drive(0, 2, 0, 1, 0); ticks("os2", 4);

      // Period 15 auto-reload: no underflow wrap
      drive(1, 15, 1, 1, 0); tick("ar15_start");
      drive(0, 15, 1, 1, 0); ticks("ar15", 40);
      drive(0, 15, 1, 1, 1); tick("ar15_abort");

      // Async reset mid-run at count 6
      drive(1, 9, 0, 1, 0); tick("rst_start");
      drive(0, 9, 0, 1, 0); ticks("rst_run", 3);
      #3 reset_n = 1'b0;
      model_reset();
      #1 check_all("async_reset");
      tick("in_reset");
      reset_n = 1'b1;
      ticks("post_reset_idle", 4);

      // Randomised traffic
      for (int i = 0; i < 1500; i++) begin
         drive(($urandom % 8) == 0, int'($urandom % 16), 1'($urandom % 2),
               ($urandom % 5) != 0, ($urandom % 40) == 0);
         tick("rand");
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
